// File: rtl/alu_pkg.sv
// Shared ALU constants: default datapath sizes, add/sub operation encoding
// and the status-flag bundle carried alongside a result.
package alu_pkg;
  localparam int ALU_WIDTH = 32;
  localparam int ALU_GROUP = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } alu_flags_t;
endpackage

// File: rtl/cla_slice.sv
// Combinational carry-lookahead adder slice built from GROUP-bit groups; zero latency.
// Also exposes the carry into its MSB so the caller can derive signed overflow.
module cla_slice
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int GROUP = ALU_GROUP
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);
  localparam int NG = W / GROUP;

  always_comb begin
    logic [W-1:0]  g;
    logic [W-1:0]  p;
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG:0]   grp_c;
    logic [W:0]    c;
    logic          acc_g;
    logic          acc_p;
    logic          bc;

    g     = a_i & b_i;
    p     = a_i ^ b_i;
    grp_g = '0;
    grp_p = '0;
    acc_g = 1'b0;
    acc_p = 1'b1;
    bc    = 1'b0;
    c     = '0;

    // Group generate/propagate, then group-level carries, then bit carries per group.
    for (int i = 0; i < NG; i++) begin
      acc_g = 1'b0;
      acc_p = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        acc_g = g[i*GROUP+j] | (p[i*GROUP+j] & acc_g);
        acc_p = acc_p & p[i*GROUP+j];
      end
      grp_g[i] = acc_g;
      grp_p[i] = acc_p;
    end

    grp_c[0] = cin_i;
    for (int i = 0; i < NG; i++) begin
      grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
    end

    for (int i = 0; i < NG; i++) begin
      bc = grp_c[i];
      for (int j = 0; j < GROUP; j++) begin
        c[i*GROUP+j] = bc;
        bc = g[i*GROUP+j] | (p[i*GROUP+j] & bc);
      end
    end
    c[W] = grp_c[NG];

    sum_o  = p ^ c[W-1:0];
    cout_o = c[W];
    cmsb_o = c[W-1];
  end
endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract, one WIDTH/STAGES slice of the carry chain per stage; latency STAGES.
// in_ready ripples combinationally back from out_ready; empty stages fill even while the output stalls.
module pipe_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int STAGES = 4,
  parameter int GROUP  = ALU_GROUP
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);
  localparam int S = WIDTH / STAGES;
  localparam int L = STAGES - 1;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] en;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic              sub_q [STAGES];
  logic              cy_q  [STAGES];
  alu_flags_t        flags_q, flags_d;

  logic              src_vld [STAGES];
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic              src_sub [STAGES];
  logic              src_cin [STAGES];
  logic [WIDTH-1:0]  sum_d   [STAGES];

  logic [S-1:0]      sl_a    [STAGES];
  logic [S-1:0]      sl_b    [STAGES];
  logic [S-1:0]      sl_sum  [STAGES];
  logic              sl_cout [STAGES];
  logic              sl_cmsb [STAGES];

  // A stage may load when it, or any stage after it, is empty, or the output is draining.
  always_comb begin
    logic full;
    full = 1'b1;
    en   = '0;
    for (int k = 0; k < STAGES; k++) begin
      full = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        full = full & vld_q[j];
      end
      en[k] = ~full | out_ready;
    end
  end

  assign in_ready = en[0];

  always_comb begin
    src_vld[0] = in_valid;
    src_a[0]   = in_a;
    src_b[0]   = in_b;
    src_sub[0] = in_sub;
    src_cin[0] = in_cin;
    src_sum[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_sub[k] = sub_q[k-1];
      src_cin[k] = cy_q[k-1];
      src_sum[k] = sum_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sl_a[k] = src_a[k][k*S +: S];
      sl_b[k] = src_b[k][k*S +: S] ^ {S{src_sub[k] == OP_SUB}};
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_slice #(.W(S), .GROUP(GROUP)) u_slice (
      .a_i    (sl_a[k]),
      .b_i    (sl_b[k]),
      .cin_i  (src_cin[k]),
      .sum_o  (sl_sum[k]),
      .cout_o (sl_cout[k]),
      .cmsb_o (sl_cmsb[k])
    );
  end

  // Flags are forced to zero for bubbles so out_zero never asserts without out_valid.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]          = src_sum[k];
      sum_d[k][k*S +: S] = sl_sum[k];
    end
    flags_d = '0;
    if (src_vld[L]) begin
      flags_d.cout = sl_cout[L];
      flags_d.ovf  = sl_cout[L] ^ sl_cmsb[L];
      flags_d.zero = (sum_d[L] == '0);
      flags_d.neg  = sum_d[L][WIDTH-1];
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      vld_q   <= '0;
      flags_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
        sub_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          vld_q[k] <= src_vld[k];
          a_q[k]   <= src_a[k];
          b_q[k]   <= src_b[k];
          sum_q[k] <= sum_d[k];
          sub_q[k] <= src_sub[k];
          cy_q[k]  <= sl_cout[k];
        end
      end
      if (en[L]) begin
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = vld_q[L];
  assign out_sum   = sum_q[L];
  assign out_cout  = flags_q.cout;
  assign out_ovf   = flags_q.ovf;
  assign out_zero  = flags_q.zero;
  assign out_neg   = flags_q.neg;
endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub at WIDTH=32, STAGES=4 with hand-computed results.
module tb_pipe_addsub;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] s;
    logic [3:0]  f;   // {cout, ovf, zero, neg}
  } beat_t;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;
  logic        out_neg;

  always #5 clock = ~clock;

  pipe_addsub #(.WIDTH(32), .STAGES(4), .GROUP(4)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  int    n_chk  = 0;
  int    n_fail = 0;
  int    n_acc  = 0;
  int    n_recv = 0;
  int    cyc    = 0;
  int    first_pop = -1;
  int    last_pop  = -1;
  logic  acc = 1'b0;
  logic  pop = 1'b0;
  logic  rdy = 1'b1;
  beat_t send_q[$];
  beat_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                               input logic cin, input logic [31:0] s, input logic [3:0] f);
    beat_t t;
    t.a = a; t.b = b; t.sub = sub; t.cin = cin; t.s = s; t.f = f;
    return t;
  endfunction

  // One clock: apply last cycle's handshakes, drive, then sample at the falling edge.
  task automatic step();
    @(posedge clock);
    #1;
    if (pop) begin
      exp_q.delete(0);
      n_recv++;
    end
    if (acc) begin
      exp_q.push_back(send_q.pop_front());
      n_acc++;
    end
    in_valid = (send_q.size() != 0);
    if (send_q.size() != 0) begin
      in_a   = send_q[0].a;
      in_b   = send_q[0].b;
      in_sub = send_q[0].sub;
      in_cin = send_q[0].cin;
    end
    out_ready = rdy;
    @(negedge clock);
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    if (pop) begin
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (out_valid) begin
      chk("out_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        chk("out_sum", out_sum, exp_q[0].s);
        chk("out_flags", {28'b0, out_cout, out_ovf, out_zero, out_neg}, {28'b0, exp_q[0].f});
      end
    end
    cyc++;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((send_q.size() != 0 || exp_q.size() != 0 || pop) && t < 60) begin
      step();
      t++;
    end
    chk("drain_empty", send_q.size() + exp_q.size(), 32'd0);
  endtask

  initial begin
    int lat;
    int base;

    clear_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_out_cout", {31'b0, out_cout}, 32'd0);
    chk("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
    chk("rst_out_zero", {31'b0, out_zero}, 32'd0);
    chk("rst_out_neg", {31'b0, out_neg}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    clear_n = 1'b1;

    // Carry ripples through all four stages; counts edges from the accepting one.
    rdy = 1'b1;
    send_q.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b1010));
    step();
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < 20);
    chk("carry_latency", lat, 32'd4);
    drain();

    // Signed overflow on subtract.
    send_q.push_back(mk(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b1100));
    step();
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < 20);
    chk("sub_latency", lat, 32'd4);
    drain();

    // Back-to-back stream of eight beats.
    send_q.push_back(mk(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 4'b0000));
    send_q.push_back(mk(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 4'b0000));
    send_q.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFE, 4'b1001));
    send_q.push_back(mk(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b0001));
    send_q.push_back(mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0101));
    send_q.push_back(mk(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b1, 32'h0001_FFFF, 4'b0000));
    send_q.push_back(mk(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 4'b1010));
    send_q.push_back(mk(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b0001));
    first_pop = -1;
    base = n_recv;
    drain();
    chk("stream_count", n_recv - base, 32'd8);
    chk("stream_consecutive", last_pop - first_pop, 32'd7);

    // Backpressure: output stalled for six cycles mid-stream.
    rdy = 1'b0;
    send_q.push_back(mk(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 4'b0000));
    send_q.push_back(mk(32'h1000_0000, 32'h1000_0000, 1'b0, 1'b0, 32'h2000_0000, 4'b0000));
    send_q.push_back(mk(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 4'b0000));
    send_q.push_back(mk(32'h0000_00FF, 32'h0000_000F, 1'b1, 1'b1, 32'h0000_00F0, 4'b1000));
    send_q.push_back(mk(32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 32'h8000_0000, 4'b0101));
    send_q.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1001));
    base = n_acc;
    repeat (6) step();
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_held", n_acc - base, 32'd4);
    base = n_recv;
    rdy  = 1'b1;
    drain();
    chk("bp_drained", n_recv - base, 32'd6);

    // Bubble collapse behind a single stalled beat.
    rdy = 1'b0;
    send_q.push_back(mk(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 4'b0000));
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < 20);
    chk("bubble_stalled_valid", {31'b0, out_valid}, 32'd1);
    send_q.push_back(mk(32'h0000_0010, 32'h0000_0010, 1'b1, 1'b1, 32'h0000_0000, 4'b1010));
    send_q.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 4'b0000));
    send_q.push_back(mk(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0000, 4'b1010));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bubble_in_ready", {31'b0, in_ready}, 32'd1);
    end
    step();
    chk("bubble_full_in_ready", {31'b0, in_ready}, 32'd0);
    base = n_recv;
    rdy  = 1'b1;
    drain();
    chk("bubble_drained", n_recv - base, 32'd4);

    // Reset with three beats in flight, head beat presented at the output.
    rdy = 1'b0;
    send_q.push_back(mk(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 4'b0000));
    send_q.push_back(mk(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0004, 4'b0000));
    send_q.push_back(mk(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0006, 4'b0000));
    repeat (5) step();
    chk("pre_reset_valid", {31'b0, out_valid}, 32'd1);
    #2;
    clear_n = 1'b0;
    #1;
    chk("mid_reset_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_reset_zero", {31'b0, out_zero}, 32'd0);
    chk("mid_reset_in_ready", {31'b0, in_ready}, 32'd1);
    send_q.delete();
    exp_q.delete();
    acc      = 1'b0;
    pop      = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    rdy     = 1'b1;
    base    = n_recv;
    send_q.push_back(mk(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0, 32'h0000_1234, 4'b0000));
    drain();
    repeat (6) step();
    chk("post_reset_count", n_recv - base, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
